// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: state encoding,
// default widths and the timeout counter sizing helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 32;

    // Bits needed to count REQ cycles 0 .. timeout-1.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch unit: issues a req/ack fetch for the current PC, holds the word for
// the decoder and computes the PC's next address.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               hlt,
    input  logic               branch_take,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               dec_ready,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               fetch_err
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    fetch_state_t       state, state_d;
    logic               mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic               instr_valid_d;
    logic [INSTR_W-1:0] instr_out_d;
    logic [ADDR_W-1:0]  instr_pc_d;
    logic               discard, discard_d;
    logic [CW-1:0]      wait_cnt, wait_cnt_d;
    logic               fetch_err_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            discard     <= 1'b0;
            wait_cnt    <= '0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_d;
            mem_req     <= mem_req_d;
            mem_addr    <= mem_addr_d;
            instr_valid <= instr_valid_d;
            instr_out   <= instr_out_d;
            instr_pc    <= instr_pc_d;
            discard     <= discard_d;
            wait_cnt    <= wait_cnt_d;
            fetch_err   <= fetch_err_d;
        end
    end

    always_comb begin
        state_d       = state;
        mem_req_d     = mem_req;
        mem_addr_d    = mem_addr;
        instr_valid_d = instr_valid;
        instr_out_d   = instr_out;
        instr_pc_d    = instr_pc;
        discard_d     = discard;
        wait_cnt_d    = wait_cnt;
        fetch_err_d   = fetch_err;

        case (state)
            IDLE: begin
                if (!hlt && !branch_take) begin
                    mem_addr_d = pc_in;
                    mem_req_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                wait_cnt_d = wait_cnt + 1'b1;
                // A redirect arriving with the ack drops the word just like
                // one that arrived earlier in the request.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (discard || branch_take) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        instr_out_d   = mem_rdata;
                        instr_pc_d    = mem_addr;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end else if (wait_cnt == LAST_WAIT) begin
                    mem_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                    discard_d   = 1'b0;
                    state_d     = ERR;
                end else if (branch_take) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (dec_ready || branch_take) begin
                    instr_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            ERR: begin
                mem_req_d     = 1'b0;
                instr_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_next = pc_in;
        if (branch_take && state != ERR)
            pc_next = branch_target;
        else if (state == HOLD && dec_ready)
            pc_next = instr_pc + ADDR_W'(1);
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch/consume, PC wrap, redirect
// discard, decoder stall, timeout and asynchronous reset.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic [15:0] pc_in;
    logic        hlt;
    logic        branch_take;
    logic [15:0] branch_target;
    logic        dec_ready;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [15:0] instr_pc;
    logic [15:0] pc_next;
    logic        fetch_err;

    int compared = 0;
    int mismatched = 0;

    instr_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .TIMEOUT(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .pc_in        (pc_in),
        .hlt          (hlt),
        .branch_take  (branch_take),
        .branch_target(branch_target),
        .dec_ready    (dec_ready),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .pc_next      (pc_next),
        .fetch_err    (fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one ack cycle to the memory port, then withdraw it.
    task automatic serve_ack(input logic [31:0] data);
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(negedge clock);
        mem_ack   = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_req: got %h expected 0", mem_req); end
        compared++; if (mem_addr !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %h expected 0", instr_valid); end
        compared++; if (instr_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_instr_out: got %h expected 0", instr_out); end
        compared++; if (instr_pc !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_instr_pc: got %h expected 0000", instr_pc); end
        compared++; if (fetch_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %h expected 0", fetch_err); end
        compared++; if (pc_next !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_pc_next: got %h expected 0000", pc_next); end
    endtask

    task automatic test_basic_fetch;
        pc_in = 16'h0010;
        hlt   = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_req: got %h expected 1", mem_req); end
        compared++; if (mem_addr !== 16'h0010) begin mismatched++; $display("[TB] FAIL basic_addr: got %h expected 0010", mem_addr); end
        @(negedge clock);
        serve_ack(32'hDEAD0010);
        compared++; if (instr_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_valid: got %h expected 1", instr_valid); end
        compared++; if (instr_pc !== 16'h0010) begin mismatched++; $display("[TB] FAIL basic_instr_pc: got %h expected 0010", instr_pc); end
        compared++; if (instr_out !== 32'hDEAD0010) begin mismatched++; $display("[TB] FAIL basic_instr_out: got %h expected DEAD0010", instr_out); end
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_req_drop: got %h expected 0", mem_req); end
        hlt       = 1'b1;
        dec_ready = 1'b1;
        #1;
        compared++; if (pc_next !== 16'h0011) begin mismatched++; $display("[TB] FAIL basic_pc_next: got %h expected 0011", pc_next); end
        @(negedge clock);
        dec_ready = 1'b0;
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_consumed: got %h expected 0", instr_valid); end
    endtask

    task automatic test_wrap;
        pc_in = 16'hFFFF;
        hlt   = 1'b0;
        @(negedge clock);
        compared++; if (mem_addr !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL wrap_addr: got %h expected FFFF", mem_addr); end
        serve_ack(32'h0000FFFF);
        compared++; if (instr_pc !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL wrap_instr_pc: got %h expected FFFF", instr_pc); end
        hlt       = 1'b1;
        dec_ready = 1'b1;
        #1;
        compared++; if (pc_next !== 16'h0000) begin mismatched++; $display("[TB] FAIL wrap_pc_next: got %h expected 0000", pc_next); end
        @(negedge clock);
        dec_ready = 1'b0;
    endtask

    task automatic test_branch_discard;
        pc_in = 16'h0100;
        hlt   = 1'b0;
        @(negedge clock);
        compared++; if (mem_addr !== 16'h0100) begin mismatched++; $display("[TB] FAIL br_addr0: got %h expected 0100", mem_addr); end
        branch_take   = 1'b1;
        branch_target = 16'h0200;
        #1;
        compared++; if (pc_next !== 16'h0200) begin mismatched++; $display("[TB] FAIL br_pc_next: got %h expected 0200", pc_next); end
        @(negedge clock);
        branch_take = 1'b0;
        pc_in       = 16'h0200;
        serve_ack(32'hBAD00100);
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL br_dropped: got %h expected 0", instr_valid); end
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL br_req_drop: got %h expected 0", mem_req); end
        @(negedge clock);
        compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL br_refetch_req: got %h expected 1", mem_req); end
        compared++; if (mem_addr !== 16'h0200) begin mismatched++; $display("[TB] FAIL br_refetch_addr: got %h expected 0200", mem_addr); end
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL br_still_invalid: got %h expected 0", instr_valid); end
        serve_ack(32'h00000200);
        compared++; if (instr_pc !== 16'h0200) begin mismatched++; $display("[TB] FAIL br_instr_pc: got %h expected 0200", instr_pc); end
        compared++; if (instr_out !== 32'h00000200) begin mismatched++; $display("[TB] FAIL br_instr_out: got %h expected 00000200", instr_out); end
        hlt       = 1'b1;
        dec_ready = 1'b1;
        @(negedge clock);
        dec_ready = 1'b0;
    endtask

    task automatic test_hold_stall;
        pc_in = 16'h0300;
        hlt   = 1'b0;
        @(negedge clock);
        serve_ack(32'h33333333);
        for (int i = 0; i < 5; i++) begin
            compared++; if (instr_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_valid[%0d]: got %h expected 1", i, instr_valid); end
            compared++; if (instr_out !== 32'h33333333) begin mismatched++; $display("[TB] FAIL stall_instr_out[%0d]: got %h expected 33333333", i, instr_out); end
            compared++; if (instr_pc !== 16'h0300) begin mismatched++; $display("[TB] FAIL stall_instr_pc[%0d]: got %h expected 0300", i, instr_pc); end
            compared++; if (pc_next !== 16'h0300) begin mismatched++; $display("[TB] FAIL stall_pc_next[%0d]: got %h expected 0300", i, pc_next); end
            compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_no_req[%0d]: got %h expected 0", i, mem_req); end
            @(negedge clock);
        end
        dec_ready     = 1'b1;
        branch_take   = 1'b1;
        branch_target = 16'h0400;
        hlt           = 1'b1;
        #1;
        compared++; if (pc_next !== 16'h0400) begin mismatched++; $display("[TB] FAIL stall_branch_wins: got %h expected 0400", pc_next); end
        @(negedge clock);
        dec_ready = 1'b0;
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_consumed: got %h expected 0", instr_valid); end
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_hlt_idle: got %h expected 0", mem_req); end
        #1;
        compared++; if (pc_next !== 16'h0400) begin mismatched++; $display("[TB] FAIL stall_hlt_branch_pc: got %h expected 0400", pc_next); end
        branch_take = 1'b0;
    endtask

    task automatic test_timeout;
        pc_in = 16'h0500;
        hlt   = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL to_req[%0d]: got %h expected 1", i, mem_req); end
            compared++; if (fetch_err !== 1'b0) begin mismatched++; $display("[TB] FAIL to_early_err[%0d]: got %h expected 0", i, fetch_err); end
        end
        @(negedge clock);
        compared++; if (fetch_err !== 1'b1) begin mismatched++; $display("[TB] FAIL to_err: got %h expected 1", fetch_err); end
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL to_req_drop: got %h expected 0", mem_req); end
        mem_ack       = 1'b1;
        mem_rdata     = 32'h1A7E1A7E;
        branch_take   = 1'b1;
        branch_target = 16'h0700;
        #1;
        compared++; if (pc_next !== 16'h0500) begin mismatched++; $display("[TB] FAIL to_err_pc_next: got %h expected 0500", pc_next); end
        @(negedge clock);
        mem_ack     = 1'b0;
        branch_take = 1'b0;
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL to_late_ack: got %h expected 0", instr_valid); end
        compared++; if (fetch_err !== 1'b1) begin mismatched++; $display("[TB] FAIL to_sticky: got %h expected 1", fetch_err); end
        repeat (3) @(negedge clock);
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL to_terminal: got %h expected 0", mem_req); end
        compared++; if (fetch_err !== 1'b1) begin mismatched++; $display("[TB] FAIL to_sticky_late: got %h expected 1", fetch_err); end
        hlt   = 1'b1;
        reset = 1'b1;
        #1;
        compared++; if (fetch_err !== 1'b0) begin mismatched++; $display("[TB] FAIL to_reset_clear: got %h expected 0", fetch_err); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_hlt_and_async_reset;
        pc_in = 16'h0600;
        hlt   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL hlt_no_req[%0d]: got %h expected 0", i, mem_req); end
        end
        hlt = 1'b0;
        @(negedge clock);
        compared++; if (mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL ar_req: got %h expected 1", mem_req); end
        compared++; if (mem_addr !== 16'h0600) begin mismatched++; $display("[TB] FAIL ar_addr: got %h expected 0600", mem_addr); end
        #2;
        reset = 1'b1;
        #1;
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_mem_req: got %h expected 0", mem_req); end
        compared++; if (mem_addr !== 16'h0000) begin mismatched++; $display("[TB] FAIL ar_mem_addr: got %h expected 0000", mem_addr); end
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_valid: got %h expected 0", instr_valid); end
        compared++; if (instr_pc !== 16'h0000) begin mismatched++; $display("[TB] FAIL ar_instr_pc: got %h expected 0000", instr_pc); end
        compared++; if (fetch_err !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_err: got %h expected 0", fetch_err); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        pc_in         = 16'h0000;
        hlt           = 1'b0;
        branch_take   = 1'b0;
        branch_target = 16'h0000;
        dec_ready     = 1'b0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'h0;

        test_reset();
        test_basic_fetch();
        test_wrap();
        test_branch_discard();
        test_hold_stall();
        test_timeout();
        test_hlt_and_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
